port_regbank: RTL
=================

Name: port_regbank

Overview:
- Channel-port endpoint: a 16-byte register bank on one user channel of channelif6, attached the same way as other port_* blocks.
- Accepts command frames from the platform on the in_* side.
- Returns read-response frames to the platform on the out_* side, i.e. the responder end of the channel protocol.
- Register 0 is also exported as a status output (e.g. for LEDs).

Parameters:
- ADDR_W, 4, register address width; bank depth = 2**ADDR_W bytes.

Ports:
- clk  in  1  local clock (clk_local)
- rst  in  1  synchronous active-high reset (rst_local)
- wen  in  1  write enable from channel router; input side selected
- ren  in  1  read enable from channel router; output side selected
- in_data  in  8  command/data byte from platform
- in_sof  in  1  start of input frame
- in_eof  in  1  end of input frame
- in_src_rdy  in  1  platform has valid input byte
- in_dst_rdy  out  1  block can accept input byte
- out_data  out  8  response byte
- out_sof  out  1  first response byte
- out_eof  out  1  last response byte
- out_src_rdy  out  1  response byte valid
- out_dst_rdy  in  1  platform accepts response byte
- reg0  out  8  current contents of register 0

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-high on rst.
  - Reset clears all registers to 0x00, state to IDLE, and ptr/count to 0.
  - Reset mid-frame or mid-response aborts: no further output bytes; the next frame is parsed fresh.
- Transfers:
  - Input byte taken when wen & in_src_rdy & in_dst_rdy.
  - Output byte taken when ren & out_src_rdy & out_dst_rdy.
  - No byte moves on any other cycle.
- in_dst_rdy:
  - 1 in IDLE, WR, RDLEN and DRAIN; 0 in RESP.
  - 0 during reset cycle.
- out_src_rdy = ren & (state==RESP); out_sof/out_eof/out_data are valid only when out_src_rdy=1, else 0.
- Command byte (first byte with in_sof=1):
  - bit7 = 1: read; bit7 = 0: write.
  - bits[ADDR_W-1:0] = start address; remaining bits ignored.
- States:
  - IDLE:
    - Accepted byte with sof=0 is discarded; stay IDLE.
    - Write command: ptr <= addr; go to WR, or stay IDLE if eof on the same byte.
    - Read command: ptr <= addr; go to RDLEN. If eof on the same byte: count <= 1, go to RESP.
  - WR:
    - Each accepted byte writes reg[ptr]; ptr <= ptr+1 mod 16 (wraps 15->0).
    - eof returns to IDLE after the write.
    - A byte with sof=1 is treated as a new command, not as data.
  - RDLEN:
    - Accepted byte sets count = byte[4:0]. Values 0 or >16 are clamped to 16.
    - eof on this byte -> RESP; otherwise -> DRAIN.
    - sof=1 restarts parsing as a new command.
  - DRAIN: discard bytes until eof, then RESP. sof=1 restarts as a new command.
  - RESP:
    - Emit count bytes: reg[ptr], reg[ptr+1], … with wrap.
    - out_sof on the first byte, out_eof on the last (both on one byte when count=1).
    - Advance ptr/count only on output transfer.
    - ren low or out_dst_rdy low stalls with data held stable.
    - After the eof transfer -> IDLE.
- Read data is combinational from the bank at ptr (zero latency). Response bytes reflect bank contents at emission time.
- reg0 is registered bank content and updates the cycle after a write to address 0.

Test Plan:
- Reset then frame [0x00,0xA5] (sof on byte0, eof on byte1) with wen=1 -> reg0=0xA5 one cycle after the 2nd byte; in_dst_rdy stayed 1.
- Write wrap: frame [0x0F,0x11,0x22,0x33] -> reg15=0x11, reg0=0x22, reg1=0x33. Then read [0x8F,0x03] with ren=1 and out_dst_rdy=1 -> out bytes 0x11(sof),0x22,0x33(eof) on 3 consecutive cycles.
- Backpressure: read [0x80,0x02] with out_dst_rdy toggling 1,0,0,1 -> first byte transfers, data held for 2 stall cycles, 2nd byte carries eof. in_dst_rdy=0 throughout RESP; a command offered then is not accepted until IDLE.
- Length edge cases:
  - Read [0x85,0x00] -> 16 bytes starting reg5, wrapping to reg4, eof on the 16th.
  - Single-byte read frame [0x83] (sof&eof) -> one byte reg3 with sof=eof=1.
- Framing errors:
  - Bytes with sof=0 in IDLE -> ignored, no register change.
  - Read [0x82,0x01,0xFF,0xFF(eof)] -> DRAIN, then one-byte response reg2.
- Reset mid-response: rst asserted after 2 of 8 bytes of a read -> out_src_rdy=0 next cycle, all registers read 0x00 afterwards, new write frame accepted normally.

Source files
------------

// File: rtl/port_regbank.sv
// Channel-port register bank: 2**ADDR_W bytes that are written and read with
// command frames. Read responses go back on the out_* side; register 0 is also an output.
module port_regbank #(
    parameter int ADDR_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wen,
    input  logic       ren,
    input  logic [7:0] in_data,
    input  logic       in_sof,
    input  logic       in_eof,
    input  logic       in_src_rdy,
    output logic       in_dst_rdy,
    output logic [7:0] out_data,
    output logic       out_sof,
    output logic       out_eof,
    output logic       out_src_rdy,
    input  logic       out_dst_rdy,
    output logic [7:0] reg0
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RDLEN,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              first_q;
    logic [7:0]        bank_q [DEPTH];

    logic              in_take;
    logic              out_take;
    logic              wr_en;
    logic [DEPTH-1:0]  wr_sel;
    logic [ADDR_W:0]   len_raw;
    logic [ADDR_W:0]   len_clamped;

    // Handshakes; during the reset cycle nothing is accepted and nothing is offered.
    assign in_dst_rdy  = !rst && (state_q != S_RESP);
    assign in_take     = wen && in_src_rdy && in_dst_rdy;
    assign out_src_rdy = ren && !rst && (state_q == S_RESP);
    assign out_take    = out_src_rdy && out_dst_rdy;

    assign out_data = out_src_rdy ? bank_q[ptr_q] : 8'h00;
    assign out_sof  = out_src_rdy && first_q;
    assign out_eof  = out_src_rdy && (count_q == (ADDR_W + 1)'(1));
    assign reg0     = bank_q[0];

    assign wr_en = in_take && !in_sof && (state_q == S_WR);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wr_en && (ptr_q == ADDR_W'(gi));
    end

    // A length of zero or anything beyond the bank depth means "whole bank".
    assign len_raw     = in_data[ADDR_W:0];
    assign len_clamped = ((len_raw == '0) || (len_raw > DEPTH_CNT)) ? DEPTH_CNT : len_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    bank_q[i] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            first_q <= 1'b0;
        end else if (in_take && in_sof) begin
            // Any start-of-frame byte restarts parsing, whatever state we were in.
            ptr_q <= in_data[ADDR_W-1:0];
            if (in_data[7]) begin
                if (in_eof) begin
                    count_q <= (ADDR_W + 1)'(1);
                    first_q <= 1'b1;
                    state_q <= S_RESP;
                end else begin
                    state_q <= S_RDLEN;
                end
            end else begin
                state_q <= in_eof ? S_IDLE : S_WR;
            end
        end else if (in_take) begin
            unique case (state_q)
                S_WR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (in_eof) begin
                        state_q <= S_IDLE;
                    end
                end
                S_RDLEN: begin
                    count_q <= len_clamped;
                    first_q <= 1'b1;
                    state_q <= in_eof ? S_RESP : S_DRAIN;
                end
                S_DRAIN: begin
                    if (in_eof) begin
                        first_q <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                default: begin
                end
            endcase
        end else if (out_take) begin
            ptr_q   <= ptr_q + 1'b1;
            count_q <= count_q - 1'b1;
            first_q <= 1'b0;
            if (count_q == (ADDR_W + 1)'(1)) begin
                state_q <= S_IDLE;
            end
        end
    end

endmodule
